// File: rtl/sa_feeder_if.sv
// Operand beat stream into sa_feeder: one column of A and one row of B per beat.
interface sa_feeder_if #(
    parameter int WIDTH = 8,
    parameter int N     = 2
);
    logic                      s_valid;
    logic                      s_ready;
    logic [N-1:0][WIDTH-1:0]   s_a;
    logic [N-1:0][WIDTH-1:0]   s_b;

    modport master (output s_valid, s_a, s_b, input s_ready);
    modport slave  (input s_valid, s_a, s_b, output s_ready);
endinterface

// File: rtl/sa_feeder.sv
// Skewing operand feeder for an N x N output-stationary systolic array.
// Optional SA_FEEDER_PERF_EN adds a saturating stall_cnt output.
module sa_feeder #(
    parameter int  WIDTH = 8,
    parameter int  N     = 2,
    parameter int  K_MAX = 16,
    localparam int KW    = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    sa_feeder_if.slave              s_if,
    output logic [N-1:0][WIDTH-1:0] a_out,
    output logic [N-1:0][WIDTH-1:0] b_out,
    output logic                    en_out,
    output logic                    busy,
    output logic                    done
`ifdef SA_FEEDER_PERF_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    localparam int FW         = (N > 1) ? $clog2(2 * N - 1) : 1;
    localparam int FLUSH_LAST = (N > 1) ? (2 * N - 3) : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [KW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           fin_q, fin_d;
    logic           en_q;
    logic [KW-1:0]  k_clamp_s;
    logic           accept_s;
    logic           adv_s;

    assign k_clamp_s = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign accept_s  = s_if.s_valid & ready_q;
    // The array advances on every accepted beat and on every flush cycle.
    assign adv_s     = accept_s | (state_q == FLUSH);

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        fin_d   = 1'b0;
        done_d  = fin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_clamp_s == KW'(0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        k_d     = k_clamp_s;
                        cnt_d   = KW'(0);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    if (cnt_q == k_q - KW'(1)) begin
                        if (N == 1) begin
                            state_d = IDLE;
                            fin_d   = 1'b1;
                        end else begin
                            state_d = FLUSH;
                            fcnt_d  = FW'(0);
                        end
                    end else begin
                        cnt_d = cnt_q + KW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FLUSH: begin
                if (fcnt_q == FW'(FLUSH_LAST)) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
            en_q    <= adv_s;
        end
    end

    // Lane i delays its operand by i extra enabled steps to form the diagonal wavefront.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] a_ch_q [0:i];
        logic [WIDTH-1:0] b_ch_q [0:i];

        // Skew chain for lane i; frozen whenever the array is not advancing.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) begin
                    a_ch_q[j] <= '0;
                    b_ch_q[j] <= '0;
                end
            end else if (adv_s) begin
                a_ch_q[0] <= accept_s ? s_if.s_a[i] : '0;
                b_ch_q[0] <= accept_s ? s_if.s_b[i] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_ch_q[j] <= a_ch_q[j-1];
                    b_ch_q[j] <= b_ch_q[j-1];
                end
            end
        end

        assign a_out[i] = a_ch_q[i];
        assign b_out[i] = b_ch_q[i];
    end

`ifdef SA_FEEDER_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of LOAD cycles starved of operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= 16'd0;
        end else if ((state_q == LOAD) && !s_if.s_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign s_if.s_ready = ready_q;
    assign en_out       = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_sa_feeder.sv
// Randomized self-checking bench for sa_feeder (N=4, K_MAX=16) with a
// transaction-level reference and a behavioural systolic-array consumer.
module tb_sa_feeder;
    localparam int W  = 8;
    localparam int NN = 4;
    localparam int KM = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [4:0]             k_len;
    logic [NN-1:0][W-1:0]   a_out;
    logic [NN-1:0][W-1:0]   b_out;
    logic                   en_out;
    logic                   busy;
    logic                   done;
`ifdef SA_FEEDER_PERF_EN
    logic [15:0]            stall_cnt;
`endif

    sa_feeder_if #(.WIDTH(W), .N(NN)) sif ();

    sa_feeder #(.WIDTH(W), .N(NN), .K_MAX(KM)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .k_len  (k_len),
        .s_if   (sif),
        .a_out  (a_out),
        .b_out  (b_out),
        .en_out (en_out),
        .busy   (busy),
        .done   (done)
`ifdef SA_FEEDER_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ba [KM][NN];
    int bb [KM][NN];
    int exp_a [NN];
    int exp_b [NN];
    int c_acc [NN][NN];
    int ar [NN][NN];
    int br [NN][NN];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lane(input logic [NN-1:0][W-1:0] v, input int i);
        logic signed [W-1:0] t;
        t = v[i];
        return int'(t);
    endfunction

    function automatic int rand_op();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -128;
        if (r == 1) return 127;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Output-stationary N x N array: a flows right, b flows down, one step per en_out.
    task automatic step_array();
        int na [NN][NN];
        int nb [NN][NN];
        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) begin
                na[i][j] = (j == 0) ? lane(a_out, i) : ar[i][j-1];
                nb[i][j] = (i == 0) ? lane(b_out, j) : br[i-1][j];
                c_acc[i][j] += na[i][j] * nb[i][j];
            end
        end
        ar = na;
        br = nb;
    endtask

    task automatic drive_junk();
        for (int i = 0; i < NN; i++) begin
            sif.s_a[i] = W'($urandom);
            sif.s_b[i] = W'($urandom);
        end
    endtask

    task automatic check_lanes_zero(input string tag);
        for (int i = 0; i < NN; i++) begin
            chk({tag, "_a"}, lane(a_out, i), 0);
            chk({tag, "_b"}, lane(b_out, i), 0);
        end
    endtask

    task automatic run_job(input int k_req, input int stall_pct, input int gap,
                           input bit ex, input bit start_in_flush);
        int  k, acc, since, e_mod, en_seen, done_cnt, stalls, g, idx, ref_c;
        bit  acc_prev, exp_en, fin;
        k = (k_req > KM) ? KM : k_req;
        for (int b = 0; b < KM; b++) begin
            for (int i = 0; i < NN; i++) begin
                ba[b][i] = ex ? 0 : rand_op();
                bb[b][i] = ex ? 0 : rand_op();
            end
        end
        if (ex) begin
            ba[0][0] = 1; ba[0][1] = 3; ba[1][0] = 2; ba[1][1] = 4;
            bb[0][0] = 5; bb[0][1] = 6; bb[1][0] = 7; bb[1][1] = 8;
        end
        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) begin
                c_acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
            end
        end
        acc = 0; since = 0; e_mod = 0; en_seen = 0; done_cnt = 0; stalls = 0; g = 0;
        acc_prev = 1'b0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = 5'(k_req);
        sif.s_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (acc == k) since++;
            exp_en = acc_prev || (acc == k && since >= 1 && since <= 2 * NN - 1);
            chk("en_out", int'(en_out), int'(exp_en));
            chk("s_ready", int'(sif.s_ready), int'(acc < k));
            chk("busy", int'(busy), int'(acc < k || since <= 2 * NN - 2));
            chk("done", int'(done), int'(acc == k && since == 2 * NN));
            if (exp_en) begin
                for (int i = 0; i < NN; i++) begin
                    idx = e_mod - i;
                    exp_a[i] = (idx >= 0 && idx < k) ? ba[idx][i] : 0;
                    exp_b[i] = (idx >= 0 && idx < k) ? bb[idx][i] : 0;
                end
                e_mod++;
            end
            for (int i = 0; i < NN; i++) begin
                chk("a_out", lane(a_out, i), exp_a[i]);
                chk("b_out", lane(b_out, i), exp_b[i]);
            end
            if (en_out) begin
                step_array();
                en_seen++;
            end
            if (done) done_cnt++;
            if (acc == k && since >= 2 * NN + 1) fin = 1'b1;
            acc_prev = 1'b0;
            if (acc < k) begin
                if ((acc == 1 && g < gap) || (int'($urandom_range(0, 99)) < stall_pct)) begin
                    if (acc == 1) g++;
                    sif.s_valid = 1'b0;
                    stalls++;
                    drive_junk();
                end else begin
                    sif.s_valid = 1'b1;
                    for (int i = 0; i < NN; i++) begin
                        sif.s_a[i] = W'(ba[acc][i]);
                        sif.s_b[i] = W'(bb[acc][i]);
                    end
                    acc_prev = 1'b1;
                    acc++;
                end
            end else begin
                sif.s_valid = 1'($urandom_range(0, 1));
                drive_junk();
                if (start_in_flush && since == 2) begin
                    start = 1'b1;
                    k_len = 5'd3;
                end
            end
        end
        sif.s_valid = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        chk("en_count", en_seen, k + 2 * NN - 2);
        chk("done_count", done_cnt, 1);
        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) begin
                ref_c = 0;
                for (int b = 0; b < k; b++) ref_c += ba[b][i] * bb[b][j];
                chk("c_ij", c_acc[i][j], ref_c);
            end
        end
        if (ex) begin
            chk("ex_c00", c_acc[0][0], 19);
            chk("ex_c01", c_acc[0][1], 22);
            chk("ex_c10", c_acc[1][0], 43);
            chk("ex_c11", c_acc[1][1], 50);
        end
`ifdef SA_FEEDER_PERF_EN
        chk("stall_cnt", int'(stall_cnt), stalls);
`endif
    endtask

    task automatic zero_k_job();
        @(negedge clk);
        start = 1'b1;
        k_len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("k0_done", int'(done), 1);
        chk("k0_busy", int'(busy), 0);
        chk("k0_ready", int'(sif.s_ready), 0);
        chk("k0_en", int'(en_out), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("k0_done_after", int'(done), 0);
            chk("k0_en_after", int'(en_out), 0);
            chk("k0_busy_after", int'(busy), 0);
        end
    endtask

    task automatic reset_mid_job();
        @(negedge clk);
        start = 1'b1;
        k_len = 5'd4;
        @(negedge clk);
        start = 1'b0;
        sif.s_valid = 1'b1;
        for (int i = 0; i < NN; i++) begin
            sif.s_a[i] = W'(i + 9);
            sif.s_b[i] = W'(i + 20);
        end
        @(negedge clk);
        chk("rst_pre_en", int'(en_out), 1);
        chk("rst_pre_a0", lane(a_out, 0), 9);
        rst_n = 1'b0;
        sif.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_en", int'(en_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(sif.s_ready), 0);
        chk("rst_done", int'(done), 0);
        check_lanes_zero("rst_lane");
        for (int i = 0; i < NN; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_no_done", int'(done), 0);
            chk("rst_no_en", int'(en_out), 0);
        end
`ifdef SA_FEEDER_PERF_EN
        chk("rst_stall", int'(stall_cnt), 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        k_len = 5'd0;
        sif.s_valid = 1'b0;
        sif.s_a = '0;
        sif.s_b = '0;
        for (int i = 0; i < NN; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("init_en", int'(en_out), 0);
        chk("init_busy", int'(busy), 0);
        chk("init_done", int'(done), 0);
        chk("init_ready", int'(sif.s_ready), 0);
        check_lanes_zero("init_lane");
        rst_n = 1'b1;

        run_job(2, 0, 0, 1'b1, 1'b0);
        run_job(2, 0, 3, 1'b1, 1'b0);
        zero_k_job();
        reset_mid_job();
        run_job(2, 0, 0, 1'b1, 1'b0);
        run_job(5, 20, 0, 1'b0, 1'b1);
        run_job(3, 0, 0, 1'b0, 1'b0);
        run_job(1, 30, 0, 1'b0, 1'b1);
        run_job(16, 0, 0, 1'b0, 1'b0);
        run_job(16, 25, 0, 1'b0, 1'b0);
        run_job(20, 10, 0, 1'b0, 1'b0);
        run_job(31, 0, 0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_job(int'($urandom_range(1, KM)), int'($urandom_range(0, 40)), 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
